// File: rtl/cpu_pkg.sv
// Shared constants and types for the 19-bit pipelined CPU.
// Register-index width and the default width of the optional stall counter.
package cpu_pkg;

  localparam int REG_W       = 3;
  localparam int STALL_CNT_W = 16;

  typedef logic [REG_W-1:0] reg_idx_t;

endpackage

// File: rtl/hazard_cmp.sv
// Raw load-use match: an EX-stage load writes a register that the ID-stage
// instruction reads. Register 0 is compared like any other index.
module hazard_cmp #(
  parameter int REG_W = cpu_pkg::REG_W
) (
  input  logic             EX_memread,
  input  logic [REG_W-1:0] EX_rt,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  output logic             match
);

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit = (EX_rt == ID_rs);
    rt_hit = (EX_rt == ID_rt);
    // A double match collapses into the same single stall request.
    match  = EX_memread & (rs_hit | rt_hit);
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector between ID and EX: freezes PC and IF/ID and requests
// a bubble. Defining HAZARD_STATS_EN adds the stall_count port and register.
module hazard_detection_unit #(
  parameter int REG_W = cpu_pkg::REG_W,
  parameter int CNT_W = cpu_pkg::STALL_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EX_memread,
  input  logic [REG_W-1:0] EX_rt,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  output logic             hazard,
  output logic             PCwrite,
  output logic             IF_IDwrite
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_count
`endif
);

  logic match_w;

  hazard_cmp #(
    .REG_W (REG_W)
  ) u_cmp (
    .EX_memread (EX_memread),
    .EX_rt      (EX_rt),
    .ID_rs      (ID_rs),
    .ID_rt      (ID_rt),
    .match      (match_w)
  );

  // Detection is never gated by clk or reset, so it stays live during reset.
  always_comb begin
    hazard     = match_w;
    PCwrite    = ~match_w;
    IF_IDwrite = ~match_w;
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] stall_count_d;

  // Free-running wrap from all-ones back to zero.
  always_comb begin
    stall_count_d = stall_count_q;
    if (match_w) begin
      stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`else
  // Purely combinational build: clk, reset and CNT_W are intentionally idle.
  localparam int unused_cnt_w = CNT_W;
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ reset;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit; covers the stall counter too when
// HAZARD_STATS_EN is defined.
module tb_hazard_detection_unit;

  localparam int REG_W = 3;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             EX_memread;
  logic [REG_W-1:0] EX_rt;
  logic [REG_W-1:0] ID_rs;
  logic [REG_W-1:0] ID_rt;
  logic             hazard;
  logic             PCwrite;
  logic             IF_IDwrite;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_count;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  hazard_detection_unit #(
    .REG_W (REG_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .EX_memread (EX_memread),
    .EX_rt      (EX_rt),
    .ID_rs      (ID_rs),
    .ID_rt      (ID_rt),
    .hazard     (hazard),
    .PCwrite    (PCwrite),
    .IF_IDwrite (IF_IDwrite)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard compare point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: apply one vector and check all three detection outputs
  task automatic apply(input string tag, input logic mr, input logic [REG_W-1:0] ert,
                       input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                       input logic exp_hz);
    EX_memread = mr;
    EX_rt      = ert;
    ID_rs      = rs;
    ID_rt      = rt;
    #1;
    check({tag, ".hazard"},     {31'd0, hazard},     {31'd0, exp_hz});
    check({tag, ".PCwrite"},    {31'd0, PCwrite},    {31'd0, ~exp_hz});
    check({tag, ".IF_IDwrite"}, {31'd0, IF_IDwrite}, {31'd0, ~exp_hz});
  endtask

  initial begin
    reset      = 1'b1;
    EX_memread = 1'b0;
    EX_rt      = '0;
    ID_rs      = '0;
    ID_rt      = '0;
    #1;
    check("rst.hazard",  {31'd0, hazard},  32'd0);
    check("rst.PCwrite", {31'd0, PCwrite}, 32'd1);
`ifdef HAZARD_STATS_EN
    check("rst.stall_count", {16'd0, stall_count}, 32'd0);
`endif
    // Detection follows the inputs while reset is held
    apply("in_reset_hit", 1'b1, 3'd5, 3'd5, 3'd1, 1'b1);
    apply("in_reset_miss", 1'b1, 3'd5, 3'd4, 3'd1, 1'b0);

    @(negedge clk);
    reset = 1'b0;

    apply("idle_zero",    1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    apply("load_nomatch", 1'b1, 3'd1, 3'd3, 3'd2, 1'b0);
    apply("rt_match",     1'b1, 3'd4, 3'd2, 3'd4, 1'b1);
    apply("rs_match_r0",  1'b1, 3'd0, 3'd0, 3'd1, 1'b1);
    apply("double_r0",    1'b1, 3'd0, 3'd0, 3'd0, 1'b1);
    apply("noload_match", 1'b0, 3'd6, 3'd6, 3'd6, 1'b0);
    apply("msb_differs",  1'b1, 3'd7, 3'd3, 3'd3, 1'b0);
    apply("lsb_differs",  1'b1, 3'd6, 3'd7, 3'd7, 1'b0);
    apply("r7_rs_match",  1'b1, 3'd7, 3'd7, 3'd0, 1'b1);
    apply("drop_load",    1'b0, 3'd7, 3'd7, 3'd0, 1'b0);

`ifdef HAZARD_STATS_EN
    // Clear whatever the directed vectors accumulated
    @(negedge clk);
    EX_memread = 1'b0;
    reset      = 1'b1;
    #1;
    check("stats.clear", {16'd0, stall_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    EX_memread = 1'b1;
    EX_rt      = 3'd2;
    ID_rs      = 3'd2;
    ID_rt      = 3'd5;
    repeat (3) @(posedge clk);
    #2;
    check("stats.three", {16'd0, stall_count}, 32'd3);
    reset = 1'b1;
    #1;
    check("stats.async_clr", {16'd0, stall_count}, 32'd0);
    check("stats.hz_in_rst", {31'd0, hazard}, 32'd1);
    EX_memread = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stats.stay_zero", {16'd0, stall_count}, 32'd0);
    EX_memread = 1'b1;
    @(posedge clk);
    #1;
    check("stats.resume", {16'd0, stall_count}, 32'd1);
    EX_memread = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
